// File: rtl/addsub_seq.sv
`timescale 1ns/1ps
// addsub_seq
// Multi-cycle two's-complement adder/subtractor. An N-bit operand pair is
// added (or subtracted) K bits per clock, with the ripple carry held in a
// register between chunks, so the critical path is a K-bit adder instead of
// an N-bit one. The result takes M = N/K compute cycles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair presented
//   in_ready   block is idle and can accept an operand pair
//   a, b       N-bit operands
//   sub        0: a+b, 1: a-b (computed as a + ~b + 1)
//   sat        clamp the result to the signed range on overflow
//   out_valid  sum and flags valid, held until out_ready
//   out_ready  consumer accepts the result
//   sum        N-bit result (saturated if requested)
//   cout       carry out of bit N-1 (for subtraction 1 = no borrow)
//   ovf        signed overflow of the unsaturated result
//   zero       sum == 0, after saturation
module addsub_seq #(
    parameter int N = 32,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int M  = N / K;
    localparam int CW = (M > 1) ? $clog2(M) : 1;
    localparam logic [CW-1:0] LAST_CHUNK = CW'(M - 1);

    // Chunking only makes sense when K divides N exactly.
    generate
        if (K < 1 || K > N || (N % K) != 0) begin : g_bad_params
            $error("addsub_seq: N must be a non-zero multiple of K with 1 <= K <= N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic           sub_q;
    logic           sat_q;
    logic           carry_q;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   raw_q;

    logic [K:0]     chunk;
    logic [N-1:0]   raw_next;
    logic           ovf_next;
    logic [N-1:0]   sum_next;
    logic [N-1:0]   sat_pos;
    logic [N-1:0]   sat_neg;
    int             base;

    // One K-bit slice of the ripple adder, selected by the chunk counter.
    // raw_next is the partial result with the current chunk merged in, so on
    // the last chunk it is already the full unsaturated result and the flags
    // can be registered on the same edge that enters DONE.
    always_comb begin
        base     = int'(cnt_q) * K;
        chunk    = {1'b0, a_q[base +: K]}
                 + {1'b0, b_q[base +: K] ^ {K{sub_q}}}
                 + {{K{1'b0}}, carry_q};
        raw_next = raw_q;
        raw_next[base +: K] = chunk[K-1:0];

        // Overflow: operands (after b inversion) share a sign that the result lacks.
        ovf_next = (a_q[N-1] == (b_q[N-1] ^ sub_q)) && (raw_next[N-1] != a_q[N-1]);

        sat_pos  = {N{1'b1}} >> 1;
        sat_neg  = ~sat_pos;
        sum_next = raw_next;
        if (sat_q && ovf_next) begin
            sum_next = a_q[N-1] ? sat_neg : sat_pos;
        end
    end

    // Control FSM plus all registered outputs. The handshake in DONE uses the
    // registered out_valid, so an out_ready that is already high when the
    // result appears only completes on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            sat_q     <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            raw_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_q      <= a;
                        b_q      <= b;
                        sub_q    <= sub;
                        sat_q    <= sat;
                        carry_q  <= sub;
                        cnt_q    <= '0;
                        raw_q    <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    raw_q   <= raw_next;
                    carry_q <= chunk[K];
                    if (cnt_q == LAST_CHUNK) begin
                        cnt_q     <= '0;
                        sum       <= sum_next;
                        cout      <= chunk[K];
                        ovf       <= ovf_next;
                        zero      <= (sum_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
`timescale 1ns/1ps
// tb_addsub_seq
// Drives three addsub_seq instances (N=16/K=4, N=8/K=8, N=32/K=1) from
// shared operand buses and checks them against a plain-arithmetic model.
module tb_addsub_seq;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic        sat;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        sat;
    logic        out_ready;
    logic [2:0]  in_valid;
    logic [2:0]  in_ready;
    logic [2:0]  out_valid;
    logic [2:0]  cout;
    logic [2:0]  ovf;
    logic [2:0]  zero;
    logic [15:0] sum16;
    logic [7:0]  sum8;
    logic [31:0] sum32;

    int   n_checks;
    int   n_fail;
    int   lat [3];
    res_t got [3];

    always #5 clk = ~clk;

    addsub_seq #(.N(16), .K(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[15:0]), .b(b[15:0]), .sub(sub), .sat(sat),
        .out_valid(out_valid[0]), .out_ready(out_ready),
        .sum(sum16), .cout(cout[0]), .ovf(ovf[0]), .zero(zero[0])
    );

    addsub_seq #(.N(8), .K(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[7:0]), .b(b[7:0]), .sub(sub), .sat(sat),
        .out_valid(out_valid[1]), .out_ready(out_ready),
        .sum(sum8), .cout(cout[1]), .ovf(ovf[1]), .zero(zero[1])
    );

    addsub_seq #(.N(32), .K(1)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a), .b(b), .sub(sub), .sat(sat),
        .out_valid(out_valid[2]), .out_ready(out_ready),
        .sum(sum32), .cout(cout[2]), .ovf(ovf[2]), .zero(zero[2])
    );

    function automatic int widthOf(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int chunksOf(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] sumOf(input int i);
        case (i)
            0:       return {16'h0, sum16};
            1:       return {24'h0, sum8};
            default: return sum32;
        endcase
    endfunction

    // Exact signed/unsigned arithmetic on 64-bit integers.
    function automatic res_t refModel(input int n, input logic [31:0] ta, input logic [31:0] tb,
                                      input logic ts, input logic tt);
        res_t   r;
        longint one, mask, ua, ub, sa, sb, full, exact, maxv, minv, s;
        one   = 1;
        mask  = (one << n) - one;
        ua    = longint'(ta) & mask;
        ub    = longint'(tb) & mask;
        full  = ts ? ua + ((~ub) & mask) + one : ua + ub;
        sa    = (ua >= (one << (n - 1))) ? ua - (one << n) : ua;
        sb    = (ub >= (one << (n - 1))) ? ub - (one << n) : ub;
        exact = ts ? sa - sb : sa + sb;
        maxv  = (one << (n - 1)) - one;
        minv  = -(one << (n - 1));
        r.cout = ((full >> n) & one) != 0;
        r.ovf  = (exact > maxv) || (exact < minv);
        s      = full & mask;
        if (tt && r.ovf) begin
            s = (exact > maxv) ? maxv : (minv & mask);
        end
        r.sum  = 32'(s);
        r.zero = (s == 0);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkResult(input int i, input res_t exp, input string tag);
        checkOutput($sformatf("u%0d %s latency", i, tag), 64'(lat[i]), 64'(chunksOf(i)));
        checkOutput($sformatf("u%0d %s sum", i, tag), 64'(got[i].sum), 64'(exp.sum));
        checkOutput($sformatf("u%0d %s cout", i, tag), 64'(got[i].cout), 64'(exp.cout));
        checkOutput($sformatf("u%0d %s ovf", i, tag), 64'(got[i].ovf), 64'(exp.ovf));
        checkOutput($sformatf("u%0d %s zero", i, tag), 64'(got[i].zero), 64'(exp.zero));
    endtask

    // Present one operand pair to the selected instances, scramble the buses
    // after acceptance, wait for each result, then complete the handshake.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb,
                                 input logic ts, input logic tt, input logic [2:0] sel);
        logic [2:0] seen;
        @(negedge clk);
        a = ta; b = tb; sub = ts; sat = tt; in_valid = sel; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 3'b000;
        a = $urandom(); b = $urandom(); sub = 1'($urandom_range(0, 1)); sat = 1'($urandom_range(0, 1));
        for (int i = 0; i < 3; i++) begin
            lat[i] = 999;
            if (sel[i]) begin
                checkOutput($sformatf("u%0d busy in_ready", i), 64'(in_ready[i]), 64'd0);
                checkOutput($sformatf("u%0d early out_valid", i), 64'(out_valid[i]), 64'd0);
            end
        end
        seen = 3'b000;
        for (int cyc = 1; cyc <= 80 && (seen & sel) != sel; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (sel[i] && !seen[i] && out_valid[i]) begin
                    seen[i]     = 1'b1;
                    lat[i]      = cyc;
                    got[i].sum  = sumOf(i);
                    got[i].cout = cout[i];
                    got[i].ovf  = ovf[i];
                    got[i].zero = zero[i];
                end
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sel[i]) begin
                checkOutput($sformatf("u%0d post-handshake out_valid", i), 64'(out_valid[i]), 64'd0);
                checkOutput($sformatf("u%0d post-handshake in_ready", i), 64'(in_ready[i]), 64'd1);
            end
        end
    endtask

    task automatic waitValid16(output int cyc);
        cyc = 999;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid[0]) begin
                cyc = c;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [10];
        res_t exp;
        int   cyc;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; in_valid = 3'b000; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0;

        vecs[0] = '{16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0005, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("u%0d reset in_ready", i), 64'(in_ready[i]), 64'd1);
            checkOutput($sformatf("u%0d reset out_valid", i), 64'(out_valid[i]), 64'd0);
            checkOutput($sformatf("u%0d reset sum", i), 64'(sumOf(i)), 64'd0);
            checkOutput($sformatf("u%0d reset flags", i), 64'({cout[i], ovf[i], zero[i]}), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[v]) begin
            applyStimulus({16'h0, vecs[v].a}, {16'h0, vecs[v].b}, vecs[v].sub, vecs[v].sat, 3'b001);
            exp.sum  = {16'h0, vecs[v].sum};
            exp.cout = vecs[v].cout;
            exp.ovf  = vecs[v].ovf;
            exp.zero = vecs[v].zero;
            checkResult(0, exp, $sformatf("vec%0d", v));
        end

        // out_ready already high when the result appears.
        @(negedge clk);
        a = 32'h00FF; b = 32'h0001; sub = 1'b0; sat = 1'b0; in_valid = 3'b001; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 3'b000;
        waitValid16(cyc);
        checkOutput("early-ready latency", 64'(cyc), 64'd4);
        checkOutput("early-ready sum", 64'(sum16), 64'h0100);
        @(negedge clk);
        checkOutput("early-ready completes next edge", 64'(out_valid[0]), 64'd0);
        checkOutput("early-ready in_ready back", 64'(in_ready[0]), 64'd1);
        out_ready = 1'b0;

        // Backpressure in DONE with the inputs moving.
        @(negedge clk);
        a = 32'h4000; b = 32'h4000; sub = 1'b0; sat = 1'b1; in_valid = 3'b001;
        @(negedge clk);
        in_valid = 3'b000;
        waitValid16(cyc);
        checkOutput("stall latency", 64'(cyc), 64'd4);
        for (int s = 0; s < 5; s++) begin
            in_valid[0] = ~in_valid[0];
            a = $urandom(); b = $urandom(); sub = ~sub; sat = ~sat;
            @(negedge clk);
            checkOutput($sformatf("stall%0d out_valid", s), 64'(out_valid[0]), 64'd1);
            checkOutput($sformatf("stall%0d in_ready", s), 64'(in_ready[0]), 64'd0);
            checkOutput($sformatf("stall%0d sum", s), 64'(sum16), 64'h7FFF);
            checkOutput($sformatf("stall%0d flags", s), 64'({cout[0], ovf[0], zero[0]}), 64'b010);
        end
        in_valid = 3'b000; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checkOutput($sformatf("post-stall idle%0d", s), 64'({out_valid[0], in_ready[0]}), 64'b01);
        end

        // Reset during the second compute cycle.
        @(negedge clk);
        a = 32'h1111; b = 32'h2222; sub = 1'b0; sat = 1'b0; in_valid = 3'b001;
        @(negedge clk);
        in_valid = 3'b000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort sum", 64'(sum16), 64'd0);
        checkOutput("abort flags", 64'({out_valid[0], cout[0], ovf[0], zero[0]}), 64'd0);
        checkOutput("abort in_ready", 64'(in_ready[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            checkOutput($sformatf("abort idle%0d", s), 64'({out_valid[0], in_ready[0]}), 64'b01);
        end

        for (int op = 0; op < 1000; op++) begin
            logic [31:0] ta, tb;
            logic        ts, tt;
            ta = $urandom();
            tb = $urandom();
            ts = 1'($urandom_range(0, 1));
            tt = 1'($urandom_range(0, 1));
            applyStimulus(ta, tb, ts, tt, 3'b111);
            for (int i = 0; i < 3; i++) begin
                checkResult(i, refModel(widthOf(i), ta, tb, ts, tt), $sformatf("rand%0d", op));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
